lio_axi_ram_slave: RTL and testbench
====================================

// Module: lio_axi_ram_slave
// PURPOSE
// - AXI4 slave (responder) for the master side of the AXI clock-domain bridge; terminates bursts into an
//   on-chip MEM_DEPTH x DATA_WIDTH word array. Used as bridge test target and as small scratch RAM.
// - Independent write and read engines, one outstanding burst each; FIXED/INCR/WRAP, awlen/arlen 0..255.
// PARAMETERS
// ADDR_WIDTH  32            byte address width
// DATA_WIDTH  32            data bus width (32/64/128)
// ID_WIDTH    4             AXI ID width
// STRB_WIDTH  DATA_WIDTH/8  byte-lane count
// MEM_DEPTH   1024          array depth in words, power of 2
// PORTS
// axis_aclk                               in   1              clock
// axis_rst                                in   1              reset, synchronous, active-high
// axis_awid/awaddr/awlen/awsize/awburst   in   ID/ADDR/8/3/2  AW payload
// axis_awvalid / axis_awready             in/out 1            AW handshake
// axis_wdata/wstrb/wlast                  in   DATA/STRB/1    W payload
// axis_wvalid / axis_wready               in/out 1            W handshake
// axis_bid/bresp                          out  ID/2           B payload
// axis_bvalid / axis_bready               out/in 1            B handshake
// axis_arid/araddr/arlen/arsize/arburst   in   ID/ADDR/8/3/2  AR payload
// axis_arvalid / axis_arready             in/out 1            AR handshake
// axis_rid/rdata/rresp/rlast              out  ID/DATA/2/1    R payload
// axis_rvalid / axis_rready               out/in 1            R handshake
// BEHAVIOUR
// - Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, bid/bresp/rid/rdata/rresp/rlast=0.
//   Reset mid-burst aborts both engines to IDLE next cycle; array contents are NOT cleared.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; AW handshake at cycle N latches
//   id/addr/len/size/burst, beat cnt=0. W_DATA (from N+1): awready=0, wready=1; each W handshake writes
//   byte lanes with wstrb=1 to word idx, advances addr, cnt++. Handshake with cnt==len -> W_RESP:
//   wready=0, bvalid=1 next cycle. B handshake -> W_IDLE, awready=1 next cycle.
// - Read FSM R_IDLE->R_DATA->R_IDLE. AR handshake at N -> rvalid=1 at N+1 with beat 0. Array read is
//   combinational, rdata registered; on each R handshake the next beat loads on the same edge, so rready
//   held 1 gives one beat per cycle. rlast=1 only when cnt==len. Last handshake -> arready=1 next cycle.
// - bvalid/rvalid and their payloads held stable until ready; bid=latched awid, rid=latched arid.
// - Word idx = addr[log2(STRB_WIDTH)+log2(MEM_DEPTH)-1 : log2(STRB_WIDTH)]; upper bits ignored (alias).
// - Address step S=2^size. FIXED: addr unchanged. INCR: next=(addr & ~(S-1))+S, modulo 2^ADDR_WIDTH.
//   WRAP: W=(len+1)*S, next=(addr & ~(W-1)) | ((addr+S) & (W-1)).
// - Errors (resp SLVERR=2'b10, no array writes for whole burst, all beats still consumed/issued):
//   size>log2(STRB_WIDTH); burst==2'b11; WRAP with len not in {1,3,7,15}. Read error beats: rdata=0.
// - wlast mismatch (wlast=1 with cnt<len, or 0 at cnt==len): beats still written, burst length follows
//   awlen, bresp=SLVERR. Otherwise bresp/rresp=OKAY(2'b00).
// - Read and write engines fully concurrent; same word written and read-loaded on one edge: R gets old data.
// TESTING
// 1. INCR write awaddr=0x10 len=3 size=2 data 0x11111111..0x44444444 strb 0xF -> bvalid, bresp=0,
//    bid=awid; INCR read same -> 4 beats in order, rlast on beat 4 only, rresp=0, rid=arid.
// 2. WRAP read araddr=0x38 len=3 size=2 (32-bit bus) after writing word=addr -> data 0x38,0x3C,0x30,0x34.
// 3. Word preloaded 0; write 0xAABBCCDD strb 4'b0101 -> read back 0x00BB00DD.
// 4. awsize=3 len=1 on 32-bit bus -> 2 W beats accepted, bresp=2'b10, array unchanged; arburst=2'b11
//    len=2 -> 3 beats rdata=0 rresp=2'b10; wlast early on beat 1 of len=3 -> 4 beats, bresp=2'b10.
// 5. bready low 5 cycles -> bvalid/bid stable, awready=0; random rready -> no lost/duplicated beat;
//    rready=1 -> 1 beat/cycle; concurrent write+read bursts complete independently.
// 6. axis_rst pulsed after 2 of 4 write beats -> next cycle awready=1, wready=0, bvalid=0; new burst OK,
//    earlier written words retained.

Source files
------------

// File: rtl/lio_axi_ram_slave.sv
// AXI4 responder backed by a MEM_DEPTH x DATA_WIDTH word array; independent write and read
// engines, one outstanding burst each, FIXED/INCR/WRAP with SLVERR on unsupported bursts.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting write beats, one per W handshake
// W_RESP | holding bvalid/bid/bresp until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting read beats, next beat loads on each R handshake
module lio_axi_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic [ID_WIDTH-1:0]   axis_awid,
  input  logic [ADDR_WIDTH-1:0] axis_awaddr,
  input  logic [7:0]            axis_awlen,
  input  logic [2:0]            axis_awsize,
  input  logic [1:0]            axis_awburst,
  input  logic                  axis_awvalid,
  output logic                  axis_awready,
  input  logic [DATA_WIDTH-1:0] axis_wdata,
  input  logic [STRB_WIDTH-1:0] axis_wstrb,
  input  logic                  axis_wlast,
  input  logic                  axis_wvalid,
  output logic                  axis_wready,
  output logic [ID_WIDTH-1:0]   axis_bid,
  output logic [1:0]            axis_bresp,
  output logic                  axis_bvalid,
  input  logic                  axis_bready,
  input  logic [ID_WIDTH-1:0]   axis_arid,
  input  logic [ADDR_WIDTH-1:0] axis_araddr,
  input  logic [7:0]            axis_arlen,
  input  logic [2:0]            axis_arsize,
  input  logic [1:0]            axis_arburst,
  input  logic                  axis_arvalid,
  output logic                  axis_arready,
  output logic [ID_WIDTH-1:0]   axis_rid,
  output logic [DATA_WIDTH-1:0] axis_rdata,
  output logic [1:0]            axis_rresp,
  output logic                  axis_rlast,
  output logic                  axis_rvalid,
  input  logic                  axis_rready
);

  localparam int LANE_BITS = $clog2(STRB_WIDTH);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam int IDX_LSB   = LANE_BITS;
  localparam int IDX_MSB   = LANE_BITS + IDX_BITS - 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_bytes;
    step       = ADDR_WIDTH'(1) << size;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * step;
    case (burst)
      2'b01:   next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
      2'b10:   next_addr = (addr & ~(wrap_bytes - ADDR_WIDTH'(1))) |
                           ((addr + step) & (wrap_bytes - ADDR_WIDTH'(1)));
      default: next_addr = addr;
    endcase
  endfunction

  function automatic logic burst_err(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic bad_wrap_len;
    bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    burst_err = (int'(size) > LANE_BITS) || (burst == 2'b11) ||
                (burst == 2'b10 && bad_wrap_len);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_cnt;
  logic                  w_err;
  logic                  w_last_err;
  logic                  w_beat;
  logic                  w_beat_last;
  logic                  w_mismatch;
  logic                  mem_we;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  assign w_beat      = (w_state == W_DATA) && axis_wvalid && axis_wready;
  assign w_beat_last = (w_cnt == w_len);
  assign w_mismatch  = axis_wlast != w_beat_last;
  assign mem_we      = w_beat && !w_err && !axis_rst;

  always_ff @(posedge axis_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (axis_wstrb[b]) mem[w_addr[IDX_MSB:IDX_LSB]][b*8 +: 8] <= axis_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      w_state      <= W_IDLE;
      w_id         <= '0;
      w_addr       <= '0;
      w_len        <= '0;
      w_size       <= '0;
      w_burst      <= '0;
      w_cnt        <= '0;
      w_err        <= 1'b0;
      w_last_err   <= 1'b0;
      axis_awready <= 1'b1;
      axis_wready  <= 1'b0;
      axis_bvalid  <= 1'b0;
      axis_bid     <= '0;
      axis_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axis_awvalid && axis_awready) begin
            w_id         <= axis_awid;
            w_addr       <= axis_awaddr;
            w_len        <= axis_awlen;
            w_size       <= axis_awsize;
            w_burst      <= axis_awburst;
            w_cnt        <= '0;
            w_err        <= burst_err(axis_awlen, axis_awsize, axis_awburst);
            w_last_err   <= 1'b0;
            axis_awready <= 1'b0;
            axis_wready  <= 1'b1;
            w_state      <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (w_mismatch) w_last_err <= 1'b1;
            // Length always follows awlen; wlast only affects the response code.
            if (w_beat_last) begin
              axis_wready <= 1'b0;
              axis_bvalid <= 1'b1;
              axis_bid    <= w_id;
              axis_bresp  <= (w_err || w_last_err || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
              w_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axis_bready) begin
            axis_bvalid  <= 1'b0;
            axis_awready <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign ar_err  = burst_err(axis_arlen, axis_arsize, axis_arburst);
  assign rd_addr = (r_state == R_IDLE) ? axis_araddr : r_addr;
  assign rd_word = mem[rd_addr[IDX_MSB:IDX_LSB]];

  // r_addr always holds the address of the beat that loads on the next handshake.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      r_state      <= R_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      axis_arready <= 1'b1;
      axis_rvalid  <= 1'b0;
      axis_rid     <= '0;
      axis_rdata   <= '0;
      axis_rresp   <= RESP_OKAY;
      axis_rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axis_arvalid && axis_arready) begin
            r_addr       <= next_addr(axis_araddr, axis_arlen, axis_arsize, axis_arburst);
            r_len        <= axis_arlen;
            r_size       <= axis_arsize;
            r_burst      <= axis_arburst;
            r_cnt        <= '0;
            r_err        <= ar_err;
            axis_arready <= 1'b0;
            axis_rvalid  <= 1'b1;
            axis_rid     <= axis_arid;
            axis_rdata   <= ar_err ? '0 : rd_word;
            axis_rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            axis_rlast   <= (axis_arlen == 8'd0);
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (axis_rvalid && axis_rready) begin
            if (r_cnt == r_len) begin
              axis_rvalid  <= 1'b0;
              axis_rlast   <= 1'b0;
              axis_arready <= 1'b1;
              r_state      <= R_IDLE;
            end else begin
              r_cnt      <= r_cnt + 8'd1;
              r_addr     <= next_addr(r_addr, r_len, r_size, r_burst);
              axis_rdata <= r_err ? '0 : rd_word;
              axis_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lio_axi_ram_slave.sv
// Randomized and directed bench for lio_axi_ram_slave against a byte-level memory model
// that derives each beat's address directly from the burst rules.
module tb_lio_axi_ram_slave;
  localparam int DEPTH = 1024;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0;
  logic        bvalid, bready = 0, arvalid = 0, arready, rvalid, rready = 0, rlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] w_data_q [$];
  logic [3:0]  w_strb_q [$];
  logic [31:0] r_data_q [$];
  logic [1:0]  r_resp_q [$];
  logic        r_last_q [$];
  logic [3:0]  r_id_q [$];
  int          r_cycles, r_unstable, hold_bad;
  logic        r_first_rvalid, r_post_arready, r_post_rvalid;
  logic        w_post_bvalid, w_post_awready;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  lio_axi_ram_slave dut (
    .axis_aclk(clk), .axis_rst(rst),
    .axis_awid(awid), .axis_awaddr(awaddr), .axis_awlen(awlen), .axis_awsize(awsize),
    .axis_awburst(awburst), .axis_awvalid(awvalid), .axis_awready(awready),
    .axis_wdata(wdata), .axis_wstrb(wstrb), .axis_wlast(wlast), .axis_wvalid(wvalid),
    .axis_wready(wready),
    .axis_bid(bid), .axis_bresp(bresp), .axis_bvalid(bvalid), .axis_bready(bready),
    .axis_arid(arid), .axis_araddr(araddr), .axis_arlen(arlen), .axis_arsize(arsize),
    .axis_arburst(arburst), .axis_arvalid(arvalid), .axis_arready(arready),
    .axis_rid(rid), .axis_rdata(rdata), .axis_rresp(rresp), .axis_rlast(rlast),
    .axis_rvalid(rvalid), .axis_rready(rready)
  );

  // Address of beat i, computed in closed form from the start address.
  function automatic logic [31:0] beat_addr(logic [31:0] addr, int len, int size,
                                             logic [1:0] burst, int i);
    logic [31:0] s, w, base;
    s = 32'd1 << size;
    if (i == 0 || burst == B_FIXED) return addr;
    if (burst == B_INCR) return (addr & ~(s - 32'd1)) + s * 32'(i);
    w    = s * 32'(len + 1);
    base = addr & ~(w - 32'd1);
    return base | ((addr + s * 32'(i)) & (w - 32'd1));
  endfunction

  function automatic bit model_err(int len, int size, logic [1:0] burst);
    return size > 2 || burst == 2'b11 || (burst == B_WRAP && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic logic [1:0] model_write(logic [31:0] addr, int len, int size,
                                              logic [1:0] burst, int early_last);
    logic [31:0] a;
    bit err;
    err = model_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (!err)
        for (int b = 0; b < 4; b++)
          if (w_strb_q[i][b]) ref_mem[a[11:2]][b*8 +: 8] = w_data_q[i][b*8 +: 8];
    end
    return (err || (early_last >= 0 && early_last < len)) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr, int len, int size,
                                              logic [1:0] burst, int i);
    logic [31:0] a;
    if (model_err(len, size, burst)) return 32'h0;
    a = beat_addr(addr, len, size, burst, i);
    return ref_mem[a[11:2]];
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int early_last,
                           input int b_delay, output logic [1:0] resp, output logic [3:0] id_o);
    int guard;
    resp = 2'bxx;
    id_o = 4'bxxxx;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    guard = 0;
    while (awready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin
      n_tests++; n_fail++; awvalid = 0;
      $display("FAIL aw_timeout awready=%b required 1", awready);
      return;
    end
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = w_data_q[i]; wstrb = w_strb_q[i]; wvalid = 1;
      wlast = (early_last >= 0) ? (i == early_last) : (i == int'(len));
      guard = 0;
      while (wready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) begin
        n_tests++; n_fail++; wvalid = 0;
        $display("FAIL w_timeout beat=%0d wready=%b required 1", i, wready);
        return;
      end
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    guard = 0;
    while (bvalid !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout bvalid=%b required 1", bvalid);
      return;
    end
    hold_bad = 0;
    for (int k = 0; k < b_delay; k++) begin
      if (bvalid !== 1'b1 || bid !== id || awready !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    resp = bresp; id_o = bid; bready = 1;
    @(negedge clk);
    bready = 0;
    w_post_bvalid = bvalid; w_post_awready = awready;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit rand_ready);
    int guard;
    bit stalled;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    r_data_q.delete(); r_resp_q.delete(); r_last_q.delete(); r_id_q.delete();
    r_cycles = 0; r_unstable = 0; stalled = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    guard = 0;
    while (arready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin
      n_tests++; n_fail++; arvalid = 0;
      $display("FAIL ar_timeout arready=%b required 1", arready);
      return;
    end
    @(negedge clk);
    arvalid = 0;
    r_first_rvalid = rvalid;
    guard = 0;
    while (r_data_q.size() < int'(len) + 1 && guard < 3000) begin
      if (rvalid === 1'b1 && stalled && (rdata !== h_data || rresp !== h_resp || rlast !== h_last))
        r_unstable++;
      rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid === 1'b1 && rready) begin
        r_data_q.push_back(rdata); r_resp_q.push_back(rresp);
        r_last_q.push_back(rlast); r_id_q.push_back(rid);
        stalled = 0;
      end else if (rvalid === 1'b1) begin
        stalled = 1; h_data = rdata; h_resp = rresp; h_last = rlast;
      end
      r_cycles++;
      @(negedge clk);
      guard++;
    end
    rready = 0;
    if (guard >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL r_timeout beats=%0d required %0d", r_data_q.size(), int'(len) + 1);
    end
    r_post_arready = arready; r_post_rvalid = rvalid;
  endtask

  task automatic fill_queues(int n, bit full_strb);
    w_data_q.delete(); w_strb_q.delete();
    for (int i = 0; i < n; i++) begin
      w_data_q.push_back($urandom);
      w_strb_q.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_handshake got=%b required 11000", {awready, arready, wready, bvalid, rvalid});
    end
    n_tests++;
    if ({bid, bresp, rid, rdata, rresp, rlast} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload bid=%h bresp=%h rid=%h rdata=%h rresp=%h rlast=%b required all 0",
               bid, bresp, rid, rdata, rresp, rlast);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release got=%b required 11", {awready, arready});
    end
  endtask

  task automatic test_preload();
    logic [1:0] resp; logic [3:0] id_o, exp;
    for (int blk = 0; blk < 4; blk++) begin
      fill_queues(256, 1);
      axi_write(4'(blk), 32'(blk * 1024), 8'd255, 3'd2, B_INCR, -1, 0, resp, id_o);
      exp = model_write(32'(blk * 1024), 255, 2, B_INCR, -1);
      n_tests++;
      if (resp !== exp) begin
        n_fail++;
        $display("FAIL preload_bresp blk=%0d got=%h required %h", blk, resp, exp);
      end
    end
  endtask

  task automatic test_incr_basic();
    logic [1:0] resp; logic [3:0] id_o; logic [31:0] exp_d;
    w_data_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    w_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h5, 32'h10, 8'd3, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'h10, 3, 2, B_INCR, -1));
    n_tests++;
    if (resp !== 2'b00 || id_o !== 4'h5) begin
      n_fail++;
      $display("FAIL incr_bresp bresp=%h bid=%h required 0/5", resp, id_o);
    end
    axi_read(4'hA, 32'h10, 8'd3, 3'd2, B_INCR, 0);
    n_tests++;
    if (r_data_q.size() !== 4 || r_first_rvalid !== 1'b1 || r_cycles !== 4) begin
      n_fail++;
      $display("FAIL incr_timing beats=%0d first_rvalid=%b cycles=%0d required 4/1/4",
               r_data_q.size(), r_first_rvalid, r_cycles);
    end
    for (int i = 0; i < r_data_q.size() && i < 4; i++) begin
      exp_d = 32'h11111111 * 32'(i + 1);
      n_tests++;
      if (r_data_q[i] !== exp_d || r_last_q[i] !== (i == 3) || r_resp_q[i] !== 2'b00 ||
          r_id_q[i] !== 4'hA) begin
        n_fail++;
        $display("FAIL incr_beat%0d data=%h last=%b resp=%h id=%h required %h/%b/0/a",
                 i, r_data_q[i], r_last_q[i], r_resp_q[i], r_id_q[i], exp_d, i == 3);
      end
    end
    n_tests++;
    if (r_post_arready !== 1'b1 || r_post_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_post arready=%b rvalid=%b required 1/0", r_post_arready, r_post_rvalid);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp; logic [3:0] id_o;
    logic [31:0] exp_w [4];
    exp_w = '{32'h38, 32'h3C, 32'h30, 32'h34};
    w_data_q = '{32'h30, 32'h34, 32'h38, 32'h3C};
    w_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h1, 32'h30, 8'd3, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'h30, 3, 2, B_INCR, -1));
    axi_read(4'h2, 32'h38, 8'd3, 3'd2, B_WRAP, 0);
    n_tests++;
    if (r_data_q.size() !== 4) begin
      n_fail++;
      $display("FAIL wrap_count beats=%0d required 4", r_data_q.size());
    end
    for (int i = 0; i < r_data_q.size() && i < 4; i++) begin
      n_tests++;
      if (r_data_q[i] !== exp_w[i] || r_data_q[i] !== model_read(32'h38, 3, 2, B_WRAP, i)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d data=%h required %h", i, r_data_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] id_o;
    w_data_q = '{32'h0}; w_strb_q = '{4'hF};
    axi_write(4'h3, 32'h100, 8'd0, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'h100, 0, 2, B_INCR, -1));
    w_data_q = '{32'hAABBCCDD}; w_strb_q = '{4'b0101};
    axi_write(4'h3, 32'h100, 8'd0, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'h100, 0, 2, B_INCR, -1));
    axi_read(4'h3, 32'h100, 8'd0, 3'd2, B_INCR, 0);
    n_tests++;
    if (r_data_q.size() !== 1 || r_data_q[0] !== 32'h00BB00DD || r_last_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_merge beats=%0d data=%h required 1 beat 00bb00dd rlast",
               r_data_q.size(), r_data_q.size() > 0 ? r_data_q[0] : 32'hx);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] id_o;
    w_data_q = '{32'hDEAD0001, 32'hDEAD0002}; w_strb_q = '{4'hF, 4'hF};
    axi_write(4'h4, 32'h200, 8'd1, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'h200, 1, 2, B_INCR, -1));
    w_data_q = '{32'hFFFFFFFF, 32'hFFFFFFFF}; w_strb_q = '{4'hF, 4'hF};
    axi_write(4'h4, 32'h200, 8'd1, 3'd3, B_INCR, -1, 0, resp, id_o);
    n_tests++;
    if (resp !== 2'b10 || model_write(32'h200, 1, 3, B_INCR, -1) !== 2'b10) begin
      n_fail++;
      $display("FAIL err_size_bresp got=%h required 2", resp);
    end
    axi_read(4'h4, 32'h200, 8'd1, 3'd2, B_INCR, 0);
    n_tests++;
    if (r_data_q.size() !== 2 || r_data_q[0] !== 32'hDEAD0001 || r_data_q[1] !== 32'hDEAD0002) begin
      n_fail++;
      $display("FAIL err_size_untouched beats=%0d data0=%h required dead0001 dead0002",
               r_data_q.size(), r_data_q.size() > 0 ? r_data_q[0] : 32'hx);
    end
    axi_read(4'h6, 32'h200, 8'd2, 3'd2, 2'b11, 0);
    n_tests++;
    if (r_data_q.size() !== 3) begin
      n_fail++;
      $display("FAIL err_burst_count beats=%0d required 3", r_data_q.size());
    end
    for (int i = 0; i < r_data_q.size() && i < 3; i++) begin
      n_tests++;
      if (r_data_q[i] !== 32'h0 || r_resp_q[i] !== 2'b10 || r_last_q[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL err_burst_beat%0d data=%h resp=%h last=%b required 0/2/%b",
                 i, r_data_q[i], r_resp_q[i], r_last_q[i], i == 2);
      end
    end
    fill_queues(4, 1);
    axi_write(4'h7, 32'h300, 8'd3, 3'd2, B_INCR, 1, 0, resp, id_o);
    n_tests++;
    if (resp !== model_write(32'h300, 3, 2, B_INCR, 1) || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL err_wlast_bresp got=%h required 2", resp);
    end
    axi_read(4'h7, 32'h300, 8'd3, 3'd2, B_INCR, 0);
    for (int i = 0; i < r_data_q.size(); i++) begin
      n_tests++;
      if (r_data_q[i] !== w_data_q[i]) begin
        n_fail++;
        $display("FAIL err_wlast_data%0d got=%h required %h", i, r_data_q[i], w_data_q[i]);
      end
    end
    fill_queues(3, 1);
    axi_write(4'h8, 32'h340, 8'd2, 3'd2, B_WRAP, -1, 0, resp, id_o);
    n_tests++;
    if (resp !== 2'b10) begin
      n_fail++;
      $display("FAIL err_wrap_len_bresp got=%h required 2", resp);
    end
    void'(model_write(32'h340, 2, 2, B_WRAP, -1));
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [3:0] id_o;
    fill_queues(3, 0);
    axi_write(4'h9, 32'h500, 8'd2, 3'd2, B_INCR, -1, 5, resp, id_o);
    void'(model_write(32'h500, 2, 2, B_INCR, -1));
    n_tests++;
    if (hold_bad !== 0 || resp !== 2'b00 || id_o !== 4'h9) begin
      n_fail++;
      $display("FAIL b_hold bad_cycles=%0d bresp=%h bid=%h required 0/0/9", hold_bad, resp, id_o);
    end
    n_tests++;
    if (w_post_bvalid !== 1'b0 || w_post_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL b_release bvalid=%b awready=%b required 0/1", w_post_bvalid, w_post_awready);
    end
    axi_read(4'hB, 32'h4F0, 8'd15, 3'd2, B_INCR, 1);
    n_tests++;
    if (r_data_q.size() !== 16 || r_unstable !== 0) begin
      n_fail++;
      $display("FAIL rready_random beats=%0d unstable=%0d required 16/0", r_data_q.size(), r_unstable);
    end
    for (int i = 0; i < r_data_q.size(); i++) begin
      n_tests++;
      if (r_data_q[i] !== model_read(32'h4F0, 15, 2, B_INCR, i) || r_last_q[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL rready_random_beat%0d data=%h last=%b required %h/%b", i, r_data_q[i],
                 r_last_q[i], model_read(32'h4F0, 15, 2, B_INCR, i), i == 15);
      end
    end
    axi_read(4'hC, 32'h600, 8'd7, 3'd2, B_INCR, 0);
    n_tests++;
    if (r_cycles !== 8 || r_post_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL r_throughput cycles=%0d rvalid_after=%b required 8/0", r_cycles, r_post_rvalid);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] resp, exp; logic [3:0] id_o;
    fill_queues(8, 0);
    fork
      axi_write(4'hD, 32'h800, 8'd7, 3'd2, B_INCR, -1, 2, resp, id_o);
      axi_read(4'hE, 32'h400, 8'd7, 3'd2, B_INCR, 1);
    join
    exp = model_write(32'h800, 7, 2, B_INCR, -1);
    n_tests++;
    if (resp !== exp || id_o !== 4'hD || r_data_q.size() !== 8) begin
      n_fail++;
      $display("FAIL concurrent bresp=%h bid=%h beats=%0d required %h/d/8", resp, id_o,
               r_data_q.size(), exp);
    end
    for (int i = 0; i < r_data_q.size(); i++) begin
      n_tests++;
      if (r_data_q[i] !== model_read(32'h400, 7, 2, B_INCR, i) || r_id_q[i] !== 4'hE) begin
        n_fail++;
        $display("FAIL concurrent_beat%0d data=%h id=%h required %h/e", i, r_data_q[i], r_id_q[i],
                 model_read(32'h400, 7, 2, B_INCR, i));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp, burst; logic [3:0] id_o, id;
    logic [31:0] addr; int len, size;
    for (int it = 0; it < 16; it++) begin
      burst = 2'($urandom_range(0, 2));
      size  = $urandom_range(0, 2);
      len   = (burst == B_WRAP) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 20);
      addr  = $urandom;
      id    = 4'($urandom);
      fill_queues(len + 1, 0);
      axi_write(id, addr, 8'(len), 3'(size), burst, -1, $urandom_range(0, 3), resp, id_o);
      exp = model_write(addr, len, size, burst, -1);
      n_tests++;
      if (resp !== exp || id_o !== id) begin
        n_fail++;
        $display("FAIL rand%0d_b bresp=%h bid=%h required %h/%h", it, resp, id_o, exp, id);
      end
      axi_read(~id, addr, 8'(len), 3'(size), burst, 1);
      n_tests++;
      if (r_data_q.size() !== len + 1 || r_unstable !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_count beats=%0d unstable=%0d required %0d/0", it, r_data_q.size(),
                 r_unstable, len + 1);
      end
      for (int i = 0; i < r_data_q.size(); i++) begin
        n_tests++;
        if (r_data_q[i] !== model_read(addr, len, size, burst, i) || r_last_q[i] !== (i == len) ||
            r_resp_q[i] !== 2'b00 || r_id_q[i] !== ~id) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d data=%h last=%b resp=%h required %h/%b/0", it, i,
                   r_data_q[i], r_last_q[i], r_resp_q[i], model_read(addr, len, size, burst, i),
                   i == len);
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    logic [1:0] resp; logic [3:0] id_o; int guard;
    @(negedge clk);
    awid = 4'h2; awaddr = 32'hA00; awlen = 8'd3; awsize = 3'd2; awburst = B_INCR; awvalid = 1;
    guard = 0;
    while (awready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    @(negedge clk);
    awvalid = 0;
    w_data_q.delete(); w_strb_q.delete();
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h5A5A0000 + 32'(i); wstrb = 4'hF; wlast = 0; wvalid = 1;
      w_data_q.push_back(wdata); w_strb_q.push_back(4'hF);
      guard = 0;
      while (wready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
      @(negedge clk);
    end
    wvalid = 0;
    void'(model_write(32'hA00, 1, 2, B_INCR, -1));
    rst = 1;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_midburst got=%b required 100", {awready, wready, bvalid});
    end
    rst = 0;
    fill_queues(2, 1);
    axi_write(4'h3, 32'hA08, 8'd1, 3'd2, B_INCR, -1, 0, resp, id_o);
    void'(model_write(32'hA08, 1, 2, B_INCR, -1));
    n_tests++;
    if (resp !== 2'b00 || id_o !== 4'h3) begin
      n_fail++;
      $display("FAIL rst_new_burst bresp=%h bid=%h required 0/3", resp, id_o);
    end
    axi_read(4'h4, 32'hA00, 8'd3, 3'd2, B_INCR, 0);
    for (int i = 0; i < r_data_q.size(); i++) begin
      n_tests++;
      if (r_data_q[i] !== model_read(32'hA00, 3, 2, B_INCR, i)) begin
        n_fail++;
        $display("FAIL rst_retain%0d got=%h required %h", i, r_data_q[i],
                 model_read(32'hA00, 3, 2, B_INCR, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_incr_basic();
    test_wrap();
    test_strobe();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
